vreg_wb_arbiter: RTL and testbench
==================================

VREG_WB_ARBITER -- requirements
Module: vreg_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, vector writeback data width.
REQ-002 The block SHALL have parameter NREG, default 16, number of vector registers (address width 4).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port alu_valid  input  1  vector ALU has a writeback pending.
REQ-006 Port alu_addr  input  4  ALU destination register.
REQ-007 Port alu_data  input  DATA_W  ALU writeback data.
REQ-008 Port alu_ready  output  1  ALU request granted this cycle.
REQ-009 Port mem_valid  input  1  vector load unit has a writeback pending.
REQ-010 Port mem_addr  input  4  load destination register.
REQ-011 Port mem_data  input  DATA_W  load writeback data.
REQ-012 Port mem_ready  output  1  load request granted this cycle.
REQ-013 Port wre  output  1  register-file write enable, registered.
REQ-014 Port a3  output  4  register-file write address, registered.
REQ-015 Port wd3  output  DATA_W  register-file write data, registered.
REQ-016 Port alloc_en  input  1  issue stage marks alloc_addr as pending write.
REQ-017 Port alloc_addr  input  4  register being allocated.
REQ-018 Port chk_a1, chk_a2  input  4 each  source registers of instruction in issue.
REQ-019 Port hazard  output  1  combinational; pending[chk_a1] OR pending[chk_a2].
REQ-020 Port flush  input  1  synchronous clear of all pending bits.
REQ-021 Port pending  output  NREG  scoreboard bit vector, registered.

Function
REQ-022 Handshake: a transfer occurs in any cycle where x_valid and x_ready are both 1; x_ready SHALL be combinational from the valids and the round-robin pointer, and SHALL never be 1 while x_valid is 0.
REQ-023 Only one of alu_ready/mem_ready SHALL be 1 in any cycle.
REQ-024 Single requester valid: it SHALL be granted in that cycle.
REQ-025 Both valid: grant the requester selected by the 1-bit pointer rr (0=ALU, 1=MEM); after every grant, rr SHALL point to the non-granted requester.
REQ-026 Neither valid: rr SHALL hold its value.
REQ-027 A requester that is not granted SHALL keep valid, addr and data stable until granted. The arbiter relies on this behaviour and does not check it.
REQ-028 Latency: a grant in cycle N SHALL produce wre=1 with that requester's addr/data on a3/wd3 in cycle N+1. No grant in cycle N SHALL produce wre=0 in N+1, with a3/wd3 holding their last values.
REQ-029 Back-to-back grants SHALL sustain one write per cycle. No bubbles SHALL be inserted.
REQ-030 Same destination from both requesters in the same cycle: both SHALL be written in grant order, one cycle apart, and the last writer wins.
REQ-031 Scoreboard set: alloc_en=1 SHALL set pending[alloc_addr] at the next edge.
REQ-032 Scoreboard clear: wre=1 SHALL clear pending[a3] at the same edge the register file writes.
REQ-033 Boundary, same cycle: if alloc_en=1 and wre=1 with alloc_addr==a3, the set SHALL win and the bit ends at 1.
REQ-034 Alloc of an already-pending register: the bit SHALL stay 1. There is no counting.
REQ-035 hazard SHALL remain 1 during the cycle wre writes that register; it deasserts the cycle after.
REQ-036 flush=1 SHALL clear all pending bits at the next edge, with priority over alloc_en. It SHALL NOT affect rr, the output register, or grants.
REQ-037 Address 0 SHALL have no special meaning; all NREG registers SHALL be tracked identically.

Reset
REQ-038 While rst=1: wre=0, a3=0, wd3=0, pending=0, rr=0 (ALU first), alu_ready=0, mem_ready=0.
REQ-039 Assertion SHALL take effect immediately without waiting for clk. Deassertion SHALL be followed by normal operation from the next rising edge.
REQ-040 Reset mid-transfer: a grant in the cycle rst asserts SHALL be dropped and SHALL produce no wre.

Verification
REQ-041 Lone ALU write: alu_valid=1, addr=5, data=0xA5..A5 in cycle 0 -> alu_ready=1 in cycle 0; wre=1, a3=5, wd3=0xA5..A5 in cycle 1; wre=0 in cycle 2.
REQ-042 Contention: both valid for 4 cycles from reset, addrs 1/2 -> grant order ALU, MEM, ALU, MEM; wre high for 4 consecutive cycles with a3 = 1, 2, 1, 2.
REQ-043 Scoreboard: alloc 7, then chk_a1=7 -> hazard=1; mem write to 7 -> hazard still 1 in the wre cycle, 0 the cycle after; pending[7]=0.
REQ-044 Simultaneous alloc/clear: pending[3]=1, wre=1 with a3=3, and alloc_en=1 with addr 3 in the same cycle -> pending[3]=1 after the edge.
REQ-045 Flush versus alloc: pending=0xFFFF, flush=1 and alloc_en=1 with addr 4 -> pending=0x0000.
REQ-046 Async reset: assert rst mid-cycle while alu_valid=1 -> alu_ready, wre and pending go to 0 before the next edge; no write to the register file.

Source files
------------

// File: rtl/vreg_wb_arbiter.sv
// vreg_wb_arbiter
//   Arbitrates vector-ALU and vector-load writebacks onto the single register-file
//   write port, and keeps a pending-write scoreboard for the issue stage.
//
//   Parameters
//     DATA_W     writeback data width
//     NREG       number of vector registers (address width is $clog2(NREG))
//   Ports
//     clk, rst                        clock, asynchronous active-high reset
//     alu_valid/alu_addr/alu_data     ALU writeback request
//     alu_ready                       ALU granted this cycle (combinational)
//     mem_valid/mem_addr/mem_data     load-unit writeback request
//     mem_ready                       load granted this cycle (combinational)
//     wre, a3, wd3                    registered register-file write port
//     alloc_en, alloc_addr            mark a register as pending write
//     chk_a1, chk_a2                  sources of the instruction in issue
//     hazard                          combinational pending lookup of chk_a1/chk_a2
//     flush                           synchronous clear of all pending bits
//     pending                         registered scoreboard vector
module vreg_wb_arbiter #(
   parameter int DATA_W = 128,
   parameter int NREG   = 16,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [AW-1:0]     alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [AW-1:0]     mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              wre,
   output logic [AW-1:0]     a3,
   output logic [DATA_W-1:0] wd3,
   input  logic              alloc_en,
   input  logic [AW-1:0]     alloc_addr,
   input  logic [AW-1:0]     chk_a1,
   input  logic [AW-1:0]     chk_a2,
   output logic              hazard,
   input  logic              flush,
   output logic [NREG-1:0]   pending
);

   // Round-robin pointer: 0 favours the ALU, 1 favours the load unit.
   logic            rr_r;
   logic            rr_nxt_s;
   logic            grant_alu_s;
   logic            grant_mem_s;
   logic [NREG-1:0] pending_nxt_s;

   // Grant decode; gated by rst so a request present while reset asserts is dropped.
   always_comb begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
      if (rst) begin
         grant_alu_s = 1'b0;
         grant_mem_s = 1'b0;
      end else if (alu_valid && mem_valid) begin
         grant_alu_s = ~rr_r;
         grant_mem_s = rr_r;
      end else begin
         grant_alu_s = alu_valid;
         grant_mem_s = mem_valid;
      end
   end

   assign alu_ready = grant_alu_s;
   assign mem_ready = grant_mem_s;

   // Pointer moves to the loser after a grant and holds when nobody asks.
   always_comb begin
      rr_nxt_s = rr_r;
      if (grant_alu_s) begin
         rr_nxt_s = 1'b1;
      end else if (grant_mem_s) begin
         rr_nxt_s = 1'b0;
      end else begin
         rr_nxt_s = rr_r;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_r <= 1'b0;
      end else begin
         rr_r <= rr_nxt_s;
      end
   end

   // Register-file write port: one write per grant, address/data hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wre <= 1'b0;
         a3  <= {AW{1'b0}};
         wd3 <= {DATA_W{1'b0}};
      end else begin
         wre <= grant_alu_s | grant_mem_s;
         if (grant_alu_s) begin
            a3  <= alu_addr;
            wd3 <= alu_data;
         end else if (grant_mem_s) begin
            a3  <= mem_addr;
            wd3 <= mem_data;
         end else begin
            a3  <= a3;
            wd3 <= wd3;
         end
      end
   end

   // Scoreboard next state: clear on write, then set on alloc so a same-cycle
   // alloc of the register being written leaves it pending; flush overrides both.
   always_comb begin
      pending_nxt_s = pending;
      if (flush) begin
         pending_nxt_s = {NREG{1'b0}};
      end else begin
         if (wre) begin
            pending_nxt_s[a3] = 1'b0;
         end else begin
            pending_nxt_s = pending;
         end
         if (alloc_en) begin
            pending_nxt_s[alloc_addr] = 1'b1;
         end else begin
            pending_nxt_s[alloc_addr] = pending_nxt_s[alloc_addr];
         end
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= {NREG{1'b0}};
      end else begin
         pending <= pending_nxt_s;
      end
   end

   // Hazard reads the registered scoreboard, so it stays high through the write cycle.
   assign hazard = pending[chk_a1] | pending[chk_a2];

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
module tb_vreg_wb_arbiter;

   localparam int DATA_W = 128;
   localparam int NREG   = 16;

   logic              clk;
   logic              rst;
   logic              alu_valid;
   logic [3:0]        alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [3:0]        mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic              wre;
   logic [3:0]        a3;
   logic [DATA_W-1:0] wd3;
   logic              alloc_en;
   logic [3:0]        alloc_addr;
   logic [3:0]        chk_a1;
   logic [3:0]        chk_a2;
   logic              hazard;
   logic              flush;
   logic [NREG-1:0]   pending;

   vreg_wb_arbiter #(.DATA_W(DATA_W), .NREG(NREG)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .wre(wre), .a3(a3), .wd3(wd3),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .chk_a1(chk_a1), .chk_a2(chk_a2), .hazard(hazard),
      .flush(flush), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       av;
      logic [3:0] aa;
      logic [7:0] ad;
      logic       mv;
      logic [3:0] ma;
      logic [7:0] md;
      logic       ear;
      logic       emr;
   } vec_t;

   typedef struct {
      logic              we;
      logic [3:0]        a;
      logic [DATA_W-1:0] d;
   } wb_t;

   vec_t vecs[14];
   wb_t  exp_q[$];
   wb_t  e;
   wb_t  last;
   int   n_chk;
   int   n_err;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic av, logic [3:0] aa, logic [7:0] ad,
                               logic mv, logic [3:0] ma, logic [7:0] md,
                               logic ear, logic emr);
      vec_t v;
      v.av = av; v.aa = aa; v.ad = ad;
      v.mv = mv; v.ma = ma; v.md = md;
      v.ear = ear; v.emr = emr;
      return v;
   endfunction

   initial begin
      n_chk = 0;
      n_err = 0;
      // Pointer starts at ALU after reset; expectations follow the round-robin rule.
      vecs[0]  = mk(1'b1, 4'd1,  8'h11, 1'b1, 4'd2,  8'h22, 1'b1, 1'b0); // contention: ALU
      vecs[1]  = mk(1'b1, 4'd1,  8'h11, 1'b1, 4'd2,  8'h22, 1'b0, 1'b1); // MEM
      vecs[2]  = mk(1'b1, 4'd1,  8'h11, 1'b1, 4'd2,  8'h22, 1'b1, 1'b0); // ALU
      vecs[3]  = mk(1'b1, 4'd1,  8'h11, 1'b1, 4'd2,  8'h22, 1'b0, 1'b1); // MEM, rr->0
      vecs[4]  = mk(1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0); // idle
      vecs[5]  = mk(1'b1, 4'd5,  8'hA5, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0); // lone ALU, rr->1
      vecs[6]  = mk(1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0); // idle, rr holds 1
      vecs[7]  = mk(1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0); // idle
      vecs[8]  = mk(1'b1, 4'd3,  8'h33, 1'b1, 4'd4,  8'h44, 1'b0, 1'b1); // both: MEM (held rr)
      vecs[9]  = mk(1'b1, 4'd3,  8'h33, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0); // ALU waited, rr->1
      vecs[10] = mk(1'b1, 4'd6,  8'h61, 1'b1, 4'd6,  8'h62, 1'b0, 1'b1); // same dest: MEM first
      vecs[11] = mk(1'b1, 4'd6,  8'h61, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0); // then ALU, wins
      vecs[12] = mk(1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'hF0, 1'b0, 1'b1); // lone MEM
      vecs[13] = mk(1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0); // idle

      rst = 1'b1;
      alu_valid = 1'b1; alu_addr = 4'd9; alu_data = {16{8'h99}};
      mem_valid = 1'b1; mem_addr = 4'd8; mem_data = {16{8'h88}};
      alloc_en = 1'b0; alloc_addr = 4'd0; chk_a1 = 4'd0; chk_a2 = 4'd0; flush = 1'b0;
      last.we = 1'b0; last.a = 4'd0; last.d = {DATA_W{1'b0}};

      // Reset state, with requests present.
      #7;
      chk("rst_alu_ready", {127'd0, alu_ready}, 128'd0);
      chk("rst_mem_ready", {127'd0, mem_ready}, 128'd0);
      chk("rst_wre", {127'd0, wre}, 128'd0);
      chk("rst_a3", {124'd0, a3}, 128'd0);
      chk("rst_wd3", wd3, 128'd0);
      chk("rst_pending", {112'd0, pending}, 128'd0);
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Table-driven arbitration vectors with a writeback scoreboard.
      for (int i = 0; i < 14; i++) begin
         alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = {16{vecs[i].ad}};
         mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = {16{vecs[i].md}};
         e.we = vecs[i].ear | vecs[i].emr;
         e.a  = vecs[i].ear ? vecs[i].aa : vecs[i].ma;
         e.d  = vecs[i].ear ? {16{vecs[i].ad}} : {16{vecs[i].md}};
         exp_q.push_back(e);
         #2;
         chk($sformatf("v%0d_alu_ready", i), {127'd0, alu_ready}, {127'd0, vecs[i].ear});
         chk($sformatf("v%0d_mem_ready", i), {127'd0, mem_ready}, {127'd0, vecs[i].emr});
         tick();
         e = exp_q.pop_front();
         chk($sformatf("v%0d_wre", i), {127'd0, wre}, {127'd0, e.we});
         if (e.we) last = e;
         chk($sformatf("v%0d_a3", i), {124'd0, a3}, {124'd0, last.a});
         chk($sformatf("v%0d_wd3", i), wd3, last.d);
      end
      alu_valid = 1'b0; mem_valid = 1'b0;

      // Scoreboard: alloc 7, hazard through the write cycle, clear after.
      alloc_en = 1'b1; alloc_addr = 4'd7; chk_a1 = 4'd7; chk_a2 = 4'd0;
      #2;
      chk("sb_hazard_before", {127'd0, hazard}, 128'd0);
      tick();
      alloc_en = 1'b0;
      chk("sb_pending_set7", {112'd0, pending}, 128'h0080);
      chk("sb_hazard_set", {127'd0, hazard}, 128'd1);
      mem_valid = 1'b1; mem_addr = 4'd7; mem_data = {16{8'h77}};
      #2;
      chk("sb_mem_ready", {127'd0, mem_ready}, 128'd1);
      tick();
      mem_valid = 1'b0;
      chk("sb_wre", {127'd0, wre}, 128'd1);
      chk("sb_a3", {124'd0, a3}, 128'd7);
      chk("sb_hazard_wcycle", {127'd0, hazard}, 128'd1);
      tick();
      chk("sb_hazard_after", {127'd0, hazard}, 128'd0);
      chk("sb_pending_clr", {112'd0, pending}, 128'd0);

      // Double alloc, then simultaneous clear and alloc of register 3.
      alloc_en = 1'b1; alloc_addr = 4'd3;
      tick();
      tick();
      alloc_en = 1'b0;
      chk("dbl_alloc", {112'd0, pending}, 128'h0008);
      alu_valid = 1'b1; alu_addr = 4'd3; alu_data = {16{8'h3C}};
      #2;
      chk("sim_alu_ready", {127'd0, alu_ready}, 128'd1);
      tick();
      alu_valid = 1'b0;
      alloc_en = 1'b1; alloc_addr = 4'd3;
      chk("sim_wre", {127'd0, wre}, 128'd1);
      chk("sim_a3", {124'd0, a3}, 128'd3);
      tick();
      alloc_en = 1'b0;
      chk("sim_pending3", {112'd0, pending}, 128'h0008);

      // Fill every register, then flush beats a concurrent alloc.
      for (int r = 0; r < NREG; r++) begin
         alloc_en = 1'b1; alloc_addr = r[3:0];
         tick();
      end
      alloc_en = 1'b0;
      chk("fill_pending", {112'd0, pending}, 128'hFFFF);
      chk_a1 = 4'd0; chk_a2 = 4'd0;
      #1;
      chk("hazard_addr0", {127'd0, hazard}, 128'd1);
      flush = 1'b1; alloc_en = 1'b1; alloc_addr = 4'd4;
      tick();
      flush = 1'b0; alloc_en = 1'b0;
      chk("flush_pending", {112'd0, pending}, 128'd0);

      // Async reset mid-cycle with an ALU request in flight.
      alloc_en = 1'b1; alloc_addr = 4'd2;
      tick();
      alloc_en = 1'b0;
      alu_valid = 1'b1; alu_addr = 4'd8; alu_data = {16{8'hEE}};
      #2;
      chk("ar_alu_ready_pre", {127'd0, alu_ready}, 128'd1);
      rst = 1'b1;
      #1;
      chk("ar_alu_ready", {127'd0, alu_ready}, 128'd0);
      chk("ar_wre", {127'd0, wre}, 128'd0);
      chk("ar_pending", {112'd0, pending}, 128'd0);
      @(negedge clk);
      @(negedge clk);
      alu_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("ar_no_write", {127'd0, wre}, 128'd0);
      chk("ar_a3", {124'd0, a3}, 128'd0);
      chk("ar_wd3", wd3, 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
